ball_motion: RTL and testbench
==============================

BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 SHALL declare parameter HMAX, default 10'd639, meaning the last visible pixel column.
REQ-002 SHALL declare parameter VMAX, default 10'd479, meaning the last visible pixel row.
REQ-003 SHALL have port clk, input, 1 bit: the single 50 MHz clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port chipselect, input, 1 bit: Avalon slave select.
REQ-006 SHALL have port write, input, 1 bit: Avalon write strobe.
REQ-007 SHALL have port address, input, 3 bits: register index.
REQ-008 SHALL have port writedata, input, 8 bits: register write data.
REQ-009 SHALL have port hcount, input, 11 bits: counter value from the VGA timing block.
REQ-010 SHALL have port vcount, input, 10 bits: row counter from the VGA timing block.
REQ-011 SHALL have port ball_x, output, 10 bits: committed ball centre column.
REQ-012 SHALL have port ball_y, output, 10 bits: committed ball centre row.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a new position is committed.
REQ-014 SHALL have port bounce, output, 1 bit: one-cycle pulse, together with frame_done, when any wall was hit that frame.

Function
REQ-015 SHALL decode these registers on chipselect && write: 0 dx (signed, pixels per frame); 1 dy (signed); 2 radius (unsigned, 1..63, value 0 treated as 1); 3 ctrl (bit0 run, bit1 reload); 4 x_init[7:0]; 5 y_init[7:0]; 6 hi bits, where bits[1:0] are x_init[9:8] and bit2 is y_init[8].
REQ-016 SHALL store writes in shadow registers only; the active dx/dy/radius SHALL be loaded from the shadows at the tick, so there is no mid-frame change.
REQ-017 SHALL generate tick for exactly one cycle when hcount == 0 and vcount == VMAX+1.
REQ-018 SHALL implement FSM states IDLE, CALC_X, CALC_Y, COMMIT.
- IDLE -> CALC_X on tick; otherwise stay in IDLE.
- CALC_X -> CALC_Y -> COMMIT -> IDLE, one cycle each, unconditionally.
REQ-019 SHALL ignore a tick arriving in any state other than IDLE.
REQ-020 SHALL, in CALC_X, compute nx = x + dx in 12-bit signed arithmetic.
- If nx - r < 0: x <= r, dx negated, bounce flag set.
- Else if nx + r > HMAX: x <= HMAX - r, dx negated, bounce flag set.
- Else: x <= nx.
REQ-021 SHALL apply the same rule to y in CALC_Y using dy and VMAX.
REQ-022 SHALL saturate negation of -128 to +127; a negated velocity SHALL also be written back to the shadow register unless the shadow was written since the tick.
REQ-023 SHALL hold x, y and velocities unchanged in CALC_X and CALC_Y when ctrl.run == 0, while still stepping through the states and pulsing frame_done.
REQ-024 SHALL load x = x_init and y = y_init (ignoring motion) in CALC_X when ctrl.reload == 1 at the tick, and auto-clear ctrl.reload in COMMIT.
REQ-025 SHALL clamp x_init/y_init so that the ball lies fully on screen (r .. MAX - r) when loaded.
REQ-026 SHALL update ball_x and ball_y only in COMMIT, and pulse frame_done and bounce in that same cycle; latency from tick to output is 3 cycles.
REQ-027 SHALL take the new value when a register write coincides with the tick, for use at the next tick.

Reset
REQ-028 SHALL, on reset assertion at any time including mid-FSM, immediately force:
- state IDLE;
- ball_x = 320 and ball_y = 240;
- dx = dy = 1 and radius = 8;
- ctrl = 0, x_init = 320 and y_init = 240;
- frame_done = 0 and bounce = 0.
REQ-029 SHALL resume on the first tick after reset deasserts.

Verification
REQ-030 Run=1, dx=3, dy=-2, one tick -> 3 cycles later ball_x=323, ball_y=238, frame_done=1, bounce=0.
REQ-031 x=635, r=8, dx=5, tick -> ball_x=631, bounce=1, next tick with dy=0 -> ball_x=626.
REQ-032 dx=-128 with x=10, r=8 -> ball_x=8, active dx=+127, bounce=1.
REQ-033 Write dx=7 during CALC_Y -> current commit uses old dx; next frame moves by 7.
REQ-034 Reload with x_init=1000, y_init=2, r=8 -> ball_x=631, ball_y=8, ctrl.reload reads 0 afterward.
REQ-035 Assert reset in CALC_Y -> same cycle ball_x=320, ball_y=240, no frame_done pulse; next tick behaves normally.

Source files
------------

// File: rtl/ball_motion.sv
// Ball position engine: steps the ball once per frame at the start of vertical blanking.
// Latency: 3 cycles from tick to committed ball_x/ball_y with frame_done/bounce pulses.
// Backpressure: none; register writes are accepted every cycle, ticks outside IDLE are dropped.
module ball_motion #(
    parameter logic [9:0] HMAX = 10'd639,
    parameter logic [9:0] VMAX = 10'd479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [2:0]  address,
    input  logic [7:0]  writedata,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic        frame_done,
    output logic        bounce
);

    typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

    state_t state, state_nxt;

    // Shadow (software-visible) registers
    logic signed [7:0] dx_sh, dy_sh;
    logic [5:0]        r_sh;
    logic              run_sh, reload_sh;
    logic [9:0]        x_init;
    logic [8:0]        y_init;
    logic              dx_dirty, dy_dirty;

    // Active copies latched at the tick, stable for the whole frame
    logic signed [7:0] dx_act, dy_act;
    logic [5:0]        r_act;
    logic              run_act, reload_act;

    logic [9:0]        x_pos, y_pos;
    logic              bounce_flag;

    logic              tick, wr;
    logic              x_hit, y_hit;
    logic [9:0]        x_step, y_step;
    logic              x_wb, y_wb;

    // Velocity negation with -128 saturating to +127
    function automatic logic signed [7:0] neg_sat(input logic signed [7:0] v);
        if (v == 8'sh80)
            return 8'sh7f;
        else
            return -v;
    endfunction

    // One axis move: returns {wall_hit, new_position}
    function automatic logic [10:0] axis_step(input logic [9:0] pos,
                                              input logic signed [7:0] vel,
                                              input logic [5:0] r,
                                              input logic [9:0] lim);
        logic signed [11:0] np, rs, ls;
        np = $signed({2'b00, pos}) + $signed({{4{vel[7]}}, vel});
        rs = $signed({6'd0, r});
        ls = $signed({2'b00, lim});
        if (np - rs < 12'sd0)
            return {1'b1, 4'd0, r};
        else if (np + rs > ls)
            return {1'b1, lim - {4'd0, r}};
        else
            return {1'b0, np[9:0]};
    endfunction

    // Keep a reload position fully on screen
    function automatic logic [9:0] clamp_init(input logic [9:0] v,
                                              input logic [5:0] r,
                                              input logic [9:0] lim);
        if (v < {4'd0, r})
            return {4'd0, r};
        else if (v > lim - {4'd0, r})
            return lim - {4'd0, r};
        else
            return v;
    endfunction

    assign tick = (hcount == 11'd0) && (vcount == VMAX + 10'd1);
    assign wr   = chipselect && write;

    assign {x_hit, x_step} = axis_step(x_pos, dx_act, r_act, HMAX);
    assign {y_hit, y_step} = axis_step(y_pos, dy_act, r_act, VMAX);

    // A wall hit only counts when the frame is actually moving the ball
    assign x_wb = (state == CALC_X) && run_act && !reload_act && x_hit;
    assign y_wb = (state == CALC_Y) && run_act && !reload_act && y_hit;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state: wait for tick, then three fixed single-cycle steps
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = CALC_X;
            CALC_X:  state_nxt = CALC_Y;
            CALC_Y:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow registers: bus writes win over bounce write-back and reload auto-clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_sh     <= 8'sd1;
            dy_sh     <= 8'sd1;
            r_sh      <= 6'd8;
            run_sh    <= 1'b0;
            reload_sh <= 1'b0;
            x_init    <= 10'd320;
            y_init    <= 9'd240;
            dx_dirty  <= 1'b0;
            dy_dirty  <= 1'b0;
        end else begin
            if (wr && address == 3'd0)
                dx_sh <= writedata;
            else if (x_wb && !dx_dirty)
                dx_sh <= neg_sat(dx_act);

            if (wr && address == 3'd1)
                dy_sh <= writedata;
            else if (y_wb && !dy_dirty)
                dy_sh <= neg_sat(dy_act);

            if (wr && address == 3'd2)
                r_sh <= (writedata[5:0] == 6'd0) ? 6'd1 : writedata[5:0];

            if (wr && address == 3'd3) begin
                run_sh    <= writedata[0];
                reload_sh <= writedata[1];
            end else if (state == COMMIT) begin
                reload_sh <= 1'b0;
            end

            if (wr && address == 3'd4)
                x_init[7:0] <= writedata;
            if (wr && address == 3'd5)
                y_init[7:0] <= writedata;
            if (wr && address == 3'd6) begin
                x_init[9:8] <= writedata[1:0];
                y_init[8]   <= writedata[2];
            end

            // "Written since tick": a write landing on the tick itself counts
            if (state == IDLE && tick) begin
                dx_dirty <= wr && (address == 3'd0);
                dy_dirty <= wr && (address == 3'd1);
            end else begin
                if (wr && address == 3'd0) dx_dirty <= 1'b1;
                if (wr && address == 3'd1) dy_dirty <= 1'b1;
            end
        end
    end

    // Frame datapath: latch active copies, move each axis, commit outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dx_act      <= 8'sd1;
            dy_act      <= 8'sd1;
            r_act       <= 6'd8;
            run_act     <= 1'b0;
            reload_act  <= 1'b0;
            x_pos       <= 10'd320;
            y_pos       <= 10'd240;
            bounce_flag <= 1'b0;
            ball_x      <= 10'd320;
            ball_y      <= 10'd240;
            frame_done  <= 1'b0;
            bounce      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            bounce     <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        dx_act      <= dx_sh;
                        dy_act      <= dy_sh;
                        r_act       <= r_sh;
                        run_act     <= run_sh;
                        reload_act  <= reload_sh;
                        bounce_flag <= 1'b0;
                    end
                end
                CALC_X: begin
                    if (reload_act) begin
                        x_pos <= clamp_init(x_init, r_act, HMAX);
                        y_pos <= clamp_init({1'b0, y_init}, r_act, VMAX);
                    end else if (run_act) begin
                        x_pos <= x_step;
                        if (x_hit) begin
                            dx_act      <= neg_sat(dx_act);
                            bounce_flag <= 1'b1;
                        end
                    end
                end
                CALC_Y: begin
                    if (!reload_act && run_act) begin
                        y_pos <= y_step;
                        if (y_hit) begin
                            dy_act      <= neg_sat(dy_act);
                            bounce_flag <= 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    ball_x     <= x_pos;
                    ball_y     <= y_pos;
                    frame_done <= 1'b1;
                    bounce     <= bounce_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: directed scenarios plus randomized frames against a frame-level model.
// Checks commit latency, pulse widths, wall handling, shadow/active behaviour and reset.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ball_motion;

    localparam int HMAX = 639;
    localparam int VMAX = 479;

    logic        clk, reset, chipselect, write;
    logic [2:0]  address;
    logic [7:0]  writedata;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  ball_x, ball_y;
    logic        frame_done, bounce;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int m_dx_sh, m_dy_sh, m_r_sh, m_run, m_rl, m_xi, m_yi, m_dxd, m_dyd;
    int m_dx, m_dy, m_r, m_arun, m_arl;
    int m_x, m_y, m_bnc;

    ball_motion dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .hcount     (hcount),
        .vcount     (vcount),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .frame_done (frame_done),
        .bounce     (bounce)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sx8(input int d);
        return (d > 127) ? d - 256 : d;
    endfunction

    function automatic int negs(input int v);
        return (v == -128) ? 127 : -v;
    endfunction

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_reset();
        m_dx_sh = 1; m_dy_sh = 1; m_r_sh = 8; m_run = 0; m_rl = 0;
        m_xi = 320; m_yi = 240; m_dxd = 0; m_dyd = 0;
        m_dx = 1; m_dy = 1; m_r = 8; m_arun = 0; m_arl = 0;
        m_x = 320; m_y = 240; m_bnc = 0;
    endtask

    task automatic model_write(input int a, input int d);
        case (a)
            0: begin m_dx_sh = sx8(d); m_dxd = 1; end
            1: begin m_dy_sh = sx8(d); m_dyd = 1; end
            2: m_r_sh = ((d % 64) == 0) ? 1 : (d % 64);
            3: begin m_run = d & 1; m_rl = (d >> 1) & 1; end
            4: m_xi = (m_xi & 'h300) | d;
            5: m_yi = (m_yi & 'h100) | d;
            6: begin
                m_xi = (m_xi & 'hff) | ((d & 3) << 8);
                m_yi = (m_yi & 'hff) | (((d >> 2) & 1) << 8);
            end
            default: ;
        endcase
    endtask

    task automatic model_tick();
        m_dx = m_dx_sh; m_dy = m_dy_sh; m_r = m_r_sh;
        m_arun = m_run; m_arl = m_rl;
        m_dxd = 0; m_dyd = 0; m_bnc = 0;
    endtask

    task automatic model_axis(inout int pos, inout int vel, inout int sh,
                              input int dirty, input int lim);
        int nx;
        bit hit;
        nx  = pos + vel;
        hit = 1'b1;
        if (nx - m_r < 0)        pos = m_r;
        else if (nx + m_r > lim) pos = lim - m_r;
        else begin               pos = nx; hit = 1'b0; end
        if (hit) begin
            vel = negs(vel);
            m_bnc = 1;
            if (dirty == 0) sh = vel;
        end
    endtask

    task automatic model_finish();
        if (m_arl != 0) begin
            m_x = clampi(m_xi, m_r, HMAX - m_r);
            m_y = clampi(m_yi, m_r, VMAX - m_r);
        end else if (m_arun != 0) begin
            model_axis(m_x, m_dx, m_dx_sh, m_dxd, HMAX);
            model_axis(m_y, m_dy, m_dy_sh, m_dyd, VMAX);
        end
        m_rl = 0;
    endtask

    task automatic set_noise();
        hcount = 11'($urandom_range(1, 1599));
        vcount = 10'($urandom_range(0, 524));
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1;
        address = 3'(a); writedata = 8'(d);
        model_write(a, d);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    function automatic int rand_ctrl();
        int c;
        c = $urandom_range(0, 7);
        return (c == 0) ? 0 : (c == 1) ? 3 : 1;
    endfunction

    // One frame; optional bus write in cycle mcyc (1 = CALC_X, 2 = CALC_Y)
    task automatic frame(input string tag, input bit mid, input int mcyc,
                         input int ma, input int md);
        @(negedge clk);
        hcount = 11'd0; vcount = 10'(VMAX + 1);
        model_tick();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chipselect = 1'b0; write = 1'b0;
            if (k == 1) set_noise();
            if (mid && k == mcyc) begin
                chipselect = 1'b1; write = 1'b1;
                address = 3'(ma); writedata = 8'(md);
                model_write(ma, md);
            end
            if (k == 3) check({tag, ".fd_early"}, int'(frame_done), 0);
            if (k == 4) begin
                model_finish();
                check({tag, ".frame_done"}, int'(frame_done), 1);
                check({tag, ".ball_x"}, int'(ball_x), m_x);
                check({tag, ".ball_y"}, int'(ball_y), m_y);
                check({tag, ".bounce"}, int'(bounce), m_bnc);
            end
            if (k == 5) check({tag, ".fd_pulse"}, int'(frame_done), 0);
        end
    endtask

    task automatic no_frame(input string tag, input int hc, input int vc);
        int cnt;
        cnt = 0;
        @(negedge clk);
        hcount = 11'(hc); vcount = 10'(vc);
        @(negedge clk);
        set_noise();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            cnt += int'(frame_done);
        end
        check(tag, cnt, 0);
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0;
        address = 3'd0; writedata = 8'd0;
        hcount = 11'd5; vcount = 10'd0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("rst.ball_x", int'(ball_x), 320);
        check("rst.ball_y", int'(ball_y), 240);
        check("rst.frame_done", int'(frame_done), 0);
        check("rst.bounce", int'(bounce), 0);
        reset = 1'b0;

        // Tick decode must need both coordinates exactly
        no_frame("near_tick_h", 1, VMAX + 1);
        no_frame("near_tick_v", 0, VMAX);

        // run=0: position held, frame_done still pulses
        frame("hold", 1'b0, 0, 0, 0);

        // Basic motion: expect 323, 238, no bounce
        wr(3, 1); wr(0, 3); wr(1, 8'hFE);
        frame("basic", 1'b0, 0, 0, 0);
        check("basic.const_x", int'(ball_x), 323);

        // Right wall: reload to 635 with r=4, then r=8 dx=5 -> 631 bounce, then 626
        wr(2, 4); wr(4, 635 & 255); wr(6, 2); wr(5, 240); wr(3, 3);
        frame("right_load", 1'b0, 0, 0, 0);
        wr(2, 8); wr(0, 5); wr(1, 0);
        frame("right_hit", 1'b0, 0, 0, 0);
        check("right_hit.const", int'(ball_x), 631);
        frame("right_back", 1'b0, 0, 0, 0);
        check("right_back.const", int'(ball_x), 626);

        // dx=-128 at x=10 r=8 -> 8 with bounce, then +127 -> 135
        wr(4, 10); wr(6, 0); wr(3, 3);
        frame("sat_load", 1'b0, 0, 0, 0);
        wr(0, 8'h80);
        frame("sat_hit", 1'b0, 0, 0, 0);
        check("sat_hit.const", int'(ball_x), 8);
        frame("sat_after", 1'b0, 0, 0, 0);
        check("sat_after.const", int'(ball_x), 135);

        // Mid-frame dx write: this frame uses 2, next uses 7
        wr(0, 2);
        frame("mid_wr", 1'b1, 2, 0, 7);
        check("mid_wr.const", int'(ball_x), 137);
        frame("mid_next", 1'b0, 0, 0, 0);
        check("mid_next.const", int'(ball_x), 144);

        // Reload clamp: x_init=1000 y_init=2 r=8 -> 631, 8; reload self-clears
        wr(2, 8); wr(4, 1000 & 255); wr(5, 2); wr(6, 3); wr(3, 3);
        frame("clamp", 1'b0, 0, 0, 0);
        check("clamp.const_x", int'(ball_x), 631);
        check("clamp.const_y", int'(ball_y), 8);
        frame("after_reload", 1'b0, 0, 0, 0);

        // Tick held two cycles: second one lands in CALC_X and is dropped
        begin
            int cnt;
            cnt = 0;
            @(negedge clk);
            hcount = 11'd0; vcount = 10'(VMAX + 1);
            model_tick();
            @(negedge clk);
            @(negedge clk);
            set_noise();
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                cnt += int'(frame_done);
            end
            model_finish();
            check("dbl_tick.count", cnt, 1);
            check("dbl_tick.ball_x", int'(ball_x), m_x);
            check("dbl_tick.ball_y", int'(ball_y), m_y);
        end

        // Reset while in CALC_Y: outputs forced at once, no commit follows
        @(negedge clk);
        hcount = 11'd0; vcount = 10'(VMAX + 1);
        @(negedge clk);
        set_noise();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid.ball_x", int'(ball_x), 320);
        check("rst_mid.ball_y", int'(ball_y), 240);
        check("rst_mid.frame_done", int'(frame_done), 0);
        @(negedge clk);
        check("rst_mid.fd1", int'(frame_done), 0);
        @(negedge clk);
        check("rst_mid.fd2", int'(frame_done), 0);
        reset = 1'b0;
        model_reset();
        wr(3, 1);
        frame("post_rst", 1'b0, 0, 0, 0);
        check("post_rst.const_x", int'(ball_x), 321);
        check("post_rst.const_y", int'(ball_y), 241);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            int nw, a, d, ma, md, mcyc;
            bit mid;
            nw = $urandom_range(0, 3);
            for (int j = 0; j < nw; j++) begin
                a = $urandom_range(0, 6);
                d = (a == 3) ? rand_ctrl() : int'($urandom_range(0, 255));
                wr(a, d);
            end
            mid  = ($urandom_range(0, 3) == 0);
            mcyc = $urandom_range(1, 2);
            ma   = $urandom_range(0, 3);
            md   = (ma == 3) ? rand_ctrl() : int'($urandom_range(0, 255));
            frame("rand", mid, mcyc, ma, md);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
